fetch_unit: RTL and testbench

Instruction fetch front end for the ucrv32 core: generates sequential word addresses, issues requests on the instruction-memory request/grant/response interface, buffers returned words in a small in-order FIFO, and presents `{instruction, pc}` pairs to the decoder stage through a valid/ready handshake. Taken jumps, branches and traps flush it via a one-cycle redirect. It is the producer of the decoder's `instruction_i`.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches on the imem request/grant/response
// interface, buffers returned words in an in-order FIFO and hands {instr, pc} to the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t DepthCnt = cnt_t'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        fifo_cnt_q, fifo_cnt_d;
    cnt_t        pending_q, pending_d;
    cnt_t        stale_q, stale_d;
    ptr_t        wptr_q, wptr_d;
    ptr_t        rptr_q, rptr_d;

    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q    [DEPTH];

    logic        grant;
    logic        push;
    logic        pop;
    logic [CW:0] slots_used;
    logic [31:0] resp_pc;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign instr_valid_o = (fifo_cnt_q != '0) && !redirect_i;
    assign instr_o       = instr_valid_o ? instr_mem_q[rptr_q] : 32'h0;
    assign pc_o          = instr_valid_o ? pc_mem_q[rptr_q] : 32'h0;
    assign pop           = instr_valid_o && instr_ready_i;

    // A slot freed by this cycle's pop is reusable at once; this is what keeps a
    // zero-wait memory streaming one word per cycle with only DEPTH entries.
    assign slots_used = {1'b0, fifo_cnt_q} + {1'b0, pending_q} - {{CW{1'b0}}, pop};

    assign imem_req_o  = !rst_i && !redirect_i && (slots_used < {1'b0, DepthCnt});
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    // Only meaningful when nothing stale is outstanding: every pending request then
    // belongs to the current sequential run ending at fetch_pc_q.
    assign resp_pc = fetch_pc_q - {{(30 - CW){1'b0}}, pending_q, 2'b00};
    assign push    = imem_rvalid_i && (stale_q == '0) && !redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fifo_cnt_d = fifo_cnt_q;
        pending_d  = pending_q;
        stale_d    = stale_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            fifo_cnt_d = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            pending_d  = pending_q - cnt_t'(imem_rvalid_i);
            stale_d    = pending_q - cnt_t'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            pending_d = pending_q + cnt_t'(grant) - cnt_t'(imem_rvalid_i);
            if (imem_rvalid_i && (stale_q != '0)) begin
                stale_d = stale_q - cnt_t'(1);
            end
            if (push) begin
                wptr_d = wptr_q + ptr_t'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + ptr_t'(1);
            end
            fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            fifo_cnt_q <= '0;
            pending_q  <= '0;
            stale_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fifo_cnt_q <= fifo_cnt_d;
            pending_q  <= pending_d;
            stale_q    <= stale_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wptr_q] <= imem_rdata_i;
            pc_mem_q[wptr_q]    <= resp_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && !pop && (fifo_cnt_q == DepthCnt)));
            assert (!(imem_rvalid_i && (pending_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with in-order delayed responses and a scoreboard of
// expected {pc, instr} pairs filled on grant and drained on decoder transfers.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_gnt, imem_rvalid, instr_ready, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc;

    logic        w_rst, w_gnt, w_rvalid, w_ready, w_redirect;
    logic [31:0] w_rdata, w_redirect_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    fetch_unit u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .pc_o         (pc),
        .instr_ready_i(instr_ready),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc)
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8),
        .DEPTH   (2)
    ) u_dut_wrap (
        .clk_i        (clk),
        .rst_i        (w_rst),
        .imem_req_o   (w_req),
        .imem_addr_o  (w_addr),
        .imem_gnt_i   (w_gnt),
        .imem_rvalid_i(w_rvalid),
        .imem_rdata_i (w_rdata),
        .instr_valid_o(w_valid),
        .instr_o      (w_instr),
        .pc_o         (w_pc),
        .instr_ready_i(w_ready),
        .redirect_i   (w_redirect),
        .redirect_pc_i(w_redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } flight_t;

    flight_t     inflight[$];
    logic [63:0] exp_q[$];
    logic [31:0] w_addrs[$];
    logic [31:0] w_pcs[$];
    logic [31:0] exp_pc;
    int          cyc, last_due, dly_min, dly_max;
    int          grants, delivered;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        w_nv;
    logic [31:0] w_nd;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5EED_C0DE;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle: present responses, sample at negedge, book-keep, advance past posedge.
    task automatic step();
        int          due;
        logic [63:0] e;
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(inflight[0].addr);
            void'(inflight.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        w_rvalid = w_nv;
        w_rdata  = w_nd;
        w_nv     = 1'b0;
        @(negedge clk);
        s_req = imem_req; s_valid = instr_valid; s_addr = imem_addr; s_pc = pc; s_instr = instr;
        if (rst) begin
            exp_q.delete();
            exp_pc = 32'h0;
        end else if (redirect) begin
            check("redirect_quiet", {62'b0, imem_req, instr_valid}, 64'h0);
            exp_q.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        if (imem_req && imem_gnt) begin
            check("req_addr", {32'h0, imem_addr}, {32'h0, exp_pc});
            due = cyc + int'($urandom_range(dly_max, dly_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            inflight.push_back('{addr: imem_addr, due: due});
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
            grants++;
        end
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("deliver", {pc, instr}, e);
                delivered++;
            end
        end
        if (!instr_valid) check("idle_zero", {pc, instr}, 64'h0);
        if (w_req && w_gnt) begin
            if (w_addrs.size() < 8) w_addrs.push_back(w_addr);
            w_nv = 1'b1;
            w_nd = mem_word(w_addr);
        end
        if (w_valid && w_pcs.size() < 8) begin
            w_pcs.push_back(w_pc);
            check("wrap_instr", {32'h0, w_instr}, {32'h0, mem_word(w_pc)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        imem_gnt = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 20 && inflight.size() > 0; i++) step();
        if (inflight.size() > 0) check("mem_idle_timeout", 64'(inflight.size()), 64'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 1;
        last_due = 0;
    endtask

    initial begin
        int g0, d0, n;
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        w_rst = 1'b1; w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0; w_ready = 1'b1;
        w_redirect = 1'b0; w_redirect_pc = 32'h0; w_nv = 1'b0; w_nd = 32'h0;
        cyc = 0; last_due = 0; dly_min = 1; dly_max = 1; grants = 0; delivered = 0;
        exp_pc = 32'h0;
        @(posedge clk);
        #1;
        step();
        step();
        check("rst_req", {63'h0, s_req}, 64'h0);
        check("rst_addr", {32'h0, s_addr}, 64'h0);
        check("rst_valid", {63'h0, s_valid}, 64'h0);
        check("rst_instr_pc", {s_instr, s_pc}, 64'h0);

        // Zero-wait memory, ready held high: one instruction per cycle from cycle 3.
        imem_gnt = 1'b1; instr_ready = 1'b1;
        rst = 1'b0; w_rst = 1'b0; cyc = 1;
        step();
        check("first_req", {31'h0, s_req, s_addr}, {31'h0, 1'b1, 32'h0});
        step();
        for (int c = 3; c <= 12; c++) begin
            step();
            check("stream_valid", {63'h0, s_valid}, 64'h1);
        end

        // Decoder stalled: FIFO fills, requests stop, then drains in order.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b0; dly_min = 1; dly_max = 1;
        g0 = grants;
        repeat (10) step();
        check("stall_grants", 64'(grants - g0), 64'd2);
        check("stall_req", {63'h0, s_req}, 64'h0);
        check("stall_head", {31'h0, s_valid, s_pc}, {31'h0, 1'b1, 32'h0});
        instr_ready = 1'b1;
        d0 = delivered;
        repeat (6) step();
        check("stall_resume", {63'h0, (delivered - d0) >= 3}, 64'h1);

        // Redirect with two requests in flight: both responses dropped.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1; dly_min = 3; dly_max = 3;
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        d0 = delivered;
        n = 0;
        while (delivered == d0 && n < 30) begin
            step();
            n++;
        end
        if (delivered == d0) check("redir_timeout", 64'(delivered - d0), 64'd1);
        else check("redir_first", {s_pc, s_instr}, {32'h100, mem_word(32'h100)});

        // Redirect coinciding with a response; unaligned target.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1; dly_min = 1; dly_max = 1;
        step();
        redirect = 1'b1; redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        step();
        check("redir_resp_dropped", {63'h0, s_valid}, 64'h0);
        check("redir_aligned_req", {31'h0, s_req, s_addr}, {31'h0, 1'b1, 32'h200});
        repeat (4) step();

        // Random grant, latency, ready and occasional redirects.
        do_reset();
        dly_min = 1; dly_max = 3;
        for (int i = 0; i < 3000; i++) begin
            imem_gnt    = 1'($urandom_range(1, 0));
            instr_ready = 1'($urandom_range(1, 0));
            redirect    = ($urandom_range(39, 0) == 0);
            redirect_pc = $urandom & 32'h0000_0FFF;
            step();
        end
        redirect = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        if (w_addrs.size() < 3 || w_pcs.size() < 3) begin
            check("wrap_count", 64'(w_addrs.size() + w_pcs.size()), 64'd6);
        end else begin
            check("wrap_req0", {32'h0, w_addrs[0]}, {32'h0, 32'hFFFF_FFF8});
            check("wrap_req1", {32'h0, w_addrs[1]}, {32'h0, 32'hFFFF_FFFC});
            check("wrap_req2", {32'h0, w_addrs[2]}, {32'h0, 32'h0000_0000});
            check("wrap_pc0", {32'h0, w_pcs[0]}, {32'h0, 32'hFFFF_FFF8});
            check("wrap_pc1", {32'h0, w_pcs[1]}, {32'h0, 32'hFFFF_FFFC});
            check("wrap_pc2", {32'h0, w_pcs[2]}, {32'h0, 32'h0000_0000});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
